// File: rtl/carfield_domain_clkdiv_ctrl_if.sv
// Request/response bundle between the SoC control registers and the
// per-domain clock-divider controller.
interface carfield_domain_clkdiv_ctrl_if #(
    parameter int unsigned DivWidth = 8
);
    logic                req_valid_i;
    logic                req_ready_o;
    logic [3:0]          req_domain_i;
    logic [DivWidth-1:0] req_div_i;
    logic                rsp_valid_o;
    logic                rsp_err_o;

    modport master (
        output req_valid_i,
        output req_domain_i,
        output req_div_i,
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_err_o
    );

    modport slave (
        input  req_valid_i,
        input  req_domain_i,
        input  req_div_i,
        output req_ready_o,
        output rsp_valid_o,
        output rsp_err_o
    );
endinterface

// File: rtl/carfield_domain_clkdiv_ctrl.sv
// Runtime per-domain clock divider control: gate -> update -> ungate.
// Optional ack timeout enabled by defining CARFIELD_CLKDIV_TIMEOUT_EN.
module carfield_domain_clkdiv_ctrl #(
    parameter int unsigned NumDomains    = 6,
    parameter int unsigned DivWidth      = 8,
    parameter int unsigned DefaultDiv    = 1,
    parameter int unsigned GateCycles    = 4,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    carfield_domain_clkdiv_ctrl_if.slave   req_if,
    output logic [NumDomains-1:0]          clk_en_o,
    output logic [NumDomains*DivWidth-1:0] div_value_o,
    output logic [NumDomains-1:0]          div_valid_o,
    input  logic [NumDomains-1:0]          div_ready_i
);

    localparam int unsigned CntW = $clog2(GateCycles + 1);
    localparam logic [CntW-1:0] GateLoad = CntW'(GateCycles - 1);
    localparam logic [DivWidth-1:0] DefDiv = DivWidth'(DefaultDiv);

    if (NumDomains < 1 || NumDomains > 16 || DefaultDiv == 0 ||
        GateCycles < 1 || TimeoutCycles < 1) begin : g_bad_cfg
        $error("carfield_domain_clkdiv_ctrl: illegal configuration");
    end

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        UPDATE,
        SETTLE,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [3:0]          dom_q, dom_d;
    logic [DivWidth-1:0] new_q, new_d;
    logic [DivWidth-1:0] old_q, old_d;
    logic                err_q, err_d;
    logic                ack_q, ack_d;
    logic [DivWidth-1:0] div_q [NumDomains];
    logic [DivWidth-1:0] div_d [NumDomains];

    logic [DivWidth-1:0] cur_div;
    logic                dom_ok;
    logic                rdy_sel;

`ifdef CARFIELD_CLKDIV_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            dom_q <= '0;
            new_q <= DefDiv;
            old_q <= DefDiv;
            err_q <= 1'b0;
            ack_q <= 1'b0;
            for (int i = 0; i < NumDomains; i++) begin
                div_q[i] <= DefDiv;
            end
`ifdef CARFIELD_CLKDIV_TIMEOUT_EN
            tmo_q <= '0;
`endif
        end else begin
            cnt_q <= cnt_d;
            dom_q <= dom_d;
            new_q <= new_d;
            old_q <= old_d;
            err_q <= err_d;
            ack_q <= ack_d;
            for (int i = 0; i < NumDomains; i++) begin
                div_q[i] <= div_d[i];
            end
`ifdef CARFIELD_CLKDIV_TIMEOUT_EN
            tmo_q <= tmo_d;
`endif
        end
    end

    // Current value of the requested domain and ack of the active domain.
    always_comb begin
        cur_div = DefDiv;
        rdy_sel = 1'b0;
        dom_ok  = ({1'b0, req_if.req_domain_i} < 5'(NumDomains));
        for (int i = 0; i < NumDomains; i++) begin
            if (req_if.req_domain_i == 4'(i)) begin
                cur_div = div_q[i];
            end
            if (dom_q == 4'(i)) begin
                rdy_sel = div_ready_i[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dom_d   = dom_q;
        new_d   = new_q;
        old_d   = old_q;
        err_d   = err_q;
        ack_d   = ack_q;
        div_d   = div_q;
`ifdef CARFIELD_CLKDIV_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_if.req_valid_i) begin
                    dom_d = req_if.req_domain_i;
                    new_d = req_if.req_div_i;
                    old_d = cur_div;
                    err_d = 1'b0;
                    if (!dom_ok || req_if.req_div_i == '0) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (req_if.req_div_i == cur_div) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = GateLoad;
                        state_d = GATE;
                    end
                end
            end
            GATE: begin
                if (cnt_q == '0) begin
                    ack_d = 1'b0;
                    for (int i = 0; i < NumDomains; i++) begin
                        if (dom_q == 4'(i)) begin
                            div_d[i] = new_q;
                        end
                    end
`ifdef CARFIELD_CLKDIV_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    state_d = UPDATE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            UPDATE: begin
                if (ack_q) begin
                    cnt_d   = GateLoad;
                    state_d = SETTLE;
                end else if (rdy_sel) begin
                    ack_d = 1'b1;
                end
`ifdef CARFIELD_CLKDIV_TIMEOUT_EN
                // Divider never acked: restore the old ratio and report.
                else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
                    for (int i = 0; i < NumDomains; i++) begin
                        if (dom_q == 4'(i)) begin
                            div_d[i] = old_q;
                        end
                    end
                    err_d   = 1'b1;
                    cnt_d   = GateLoad;
                    state_d = SETTLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_if.req_ready_o = (state_q == IDLE);
        req_if.rsp_valid_o = (state_q == RESP);
        req_if.rsp_err_o   = (state_q == RESP) && err_q;
        clk_en_o           = '1;
        div_valid_o        = '0;
        div_value_o        = '0;
        for (int i = 0; i < NumDomains; i++) begin
            if (dom_q == 4'(i)) begin
                clk_en_o[i]    = !(state_q inside {GATE, UPDATE, SETTLE});
                div_valid_o[i] = (state_q == UPDATE) && !ack_q;
            end
            div_value_o[i*DivWidth +: DivWidth] = div_q[i];
        end
    end

endmodule

// File: tb/tb_carfield_domain_clkdiv_ctrl.sv
// Scoreboard bench for carfield_domain_clkdiv_ctrl: directed requests,
// response errors checked by a decoupled monitor.
module tb_carfield_domain_clkdiv_ctrl;
    localparam int N = 6;
    localparam int W = 8;
    localparam int G = 4;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   clk_en;
    logic [N*W-1:0] div_value;
    logic [N-1:0]   div_valid;
    logic [N-1:0]   div_ready;

    int checks = 0;
    int failures = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    carfield_domain_clkdiv_ctrl_if #(.DivWidth(W)) rif ();

    carfield_domain_clkdiv_ctrl #(
        .NumDomains(N),
        .DivWidth(W),
        .DefaultDiv(1),
        .GateCycles(G),
        .TimeoutCycles(T)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_if(rif),
        .clk_en_o(clk_en),
        .div_value_o(div_value),
        .div_valid_o(div_valid),
        .div_ready_i(div_ready)
    );

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rif.rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_rsp got=1 exp=0");
            end else begin
                chk("rsp_err", 64'(rif.rsp_err_o), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic run_req(input string tag, input int dom, input int dv,
                           input bit exp_err, input int exp_lat,
                           input int exp_gate, input int exp_vld,
                           input int k);
        logic [N-1:0]   en0;
        logic [N*W-1:0] v0;
        int lat, gate, vld, other;
        bit seen;
        lat = 0; gate = 0; vld = 0; other = 0; seen = 0;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(rif.req_ready_o), 64'd1);
        en0 = clk_en;
        v0  = div_value;
        div_ready = '1;
        if (k > 1) div_ready[dom] = 1'b0;
        exp_q.push_back(exp_err);
        rif.req_valid_i  = 1'b1;
        rif.req_domain_i = 4'(dom);
        rif.req_div_i    = W'(dv);
        @(posedge clk);
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge clk);
            rif.req_valid_i = 1'b0;
            if (dom < N) begin
                if (!clk_en[dom]) gate++;
                if (div_valid[dom]) vld++;
                if (vld >= k) div_ready = '1;
            end
            for (int i = 0; i < N; i++) begin
                if (i != dom && (clk_en[i] !== en0[i] ||
                    div_value[i*W +: W] !== v0[i*W +: W])) other++;
            end
            if (rif.rsp_valid_o) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        div_ready = '1;
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_gated_cycles"}, 64'(gate), 64'(exp_gate));
        chk({tag, "_div_valid_cycles"}, 64'(vld), 64'(exp_vld));
        chk({tag, "_others_disturbed"}, 64'(other), 64'd0);
    endtask

    initial begin
        rif.req_valid_i  = 1'b0;
        rif.req_domain_i = '0;
        rif.req_div_i    = '0;
        div_ready        = '1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(rif.req_ready_o), 64'd1);
        chk("rst_clk_en", 64'(clk_en), 64'h3f);
        chk("rst_div_value", 64'(div_value), 64'h010101010101);
        chk("rst_div_valid", 64'(div_valid), 64'd0);
        chk("rst_rsp_valid", 64'(rif.rsp_valid_o), 64'd0);

        run_req("upd_d2", 2, 4, 1'b0, 2*G+3, 2*G+2, 1, 1);
        chk("slot2_after", 64'(div_value[2*W +: W]), 64'd4);
        run_req("bad_dom7", 7, 3, 1'b1, 1, 0, 0, 1);
        run_req("bad_div0", 0, 0, 1'b1, 1, 0, 0, 1);
        run_req("same_d1", 1, 1, 1'b0, 1, 0, 0, 1);
        run_req("same_d2", 2, 4, 1'b0, 1, 0, 0, 1);
        run_req("slow_d5", 5, 9, 1'b0, 2*G+2+4, 2*G+1+4, 4, 4);
        chk("slot5_after", 64'(div_value[5*W +: W]), 64'd9);

        // Reset while domain 3 sits in its post-update settle window.
        @(negedge clk);
        rif.req_valid_i  = 1'b1;
        rif.req_domain_i = 4'd3;
        rif.req_div_i    = 8'd7;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            rif.req_valid_i = 1'b0;
        end
        chk("settle_d3_gated", 64'(clk_en[3]), 64'd0);
        chk("settle_d3_value", 64'(div_value[3*W +: W]), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("arst_clk_en", 64'(clk_en), 64'h3f);
        chk("arst_div_value", 64'(div_value), 64'h010101010101);
        chk("arst_div_valid", 64'(div_valid), 64'd0);
        chk("arst_rsp_valid", 64'(rif.rsp_valid_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready_after", 64'(rif.req_ready_o), 64'd1);

`ifdef CARFIELD_CLKDIV_TIMEOUT_EN
        run_req("tmo_d0", 0, 5, 1'b1, 2*G+T+1, 2*G+T, T, 1000);
        chk("slot0_reverted", 64'(div_value[0 +: W]), 64'd1);
`endif

        run_req("upd_d0", 0, 2, 1'b0, 2*G+3, 2*G+2, 1, 1);
        chk("slot0_after", 64'(div_value[0 +: W]), 64'd2);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
